noc_switch_allocator: RTL

//  Crossbar/switch allocator for the 5-port NoC router (ports L=0,N=1,E=2,W=3,S=4).

---
 rtl/noc_switch_allocator.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/noc_switch_allocator.sv
// rtl/noc_switch_allocator.sv - 5-port wormhole switch allocator with credits and stall watchdog
module noc_switch_allocator #(
  parameter int CREDITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  in_req,
  input  logic [14:0] in_dest,
  input  logic [14:0] in_flit_id,
  input  logic [4:0]  credit_ret,
  input  logic [11:0] timeout_len,
  output logic [4:0]  in_grant,
  output logic [4:0]  out_valid,
  output logic [14:0] xbar_sel,
  output logic [4:0]  timeout_err
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam logic [3:0] CREDIT_MAX = 4'(CREDITS);

  // Per-output state; index is the output port number.
  logic [4:0][0:0]  state;
  logic [4:0][2:0]  owner;
  logic [4:0][2:0]  rr;
  logic [4:0][3:0]  credit;
  logic [4:0][11:0] stall;

  logic [4:0]       owned;
  logic [4:0][4:0]  cand;
  logic [4:0]       win_found;
  logic [4:0][2:0]  win_idx;
  logic [4:0]       fire;
  logic [4:0]       xfer;
  logic [4:0]       tail_xfer;

  // Only the head and tail bits of the flit type steer the allocator.
  logic unused_flit_bits;
  assign unused_flit_bits = ^{in_flit_id[1], in_flit_id[4], in_flit_id[7],
                              in_flit_id[10], in_flit_id[13]};

  // Next input index in round-robin order (0..4, wrapping).
  function automatic logic [2:0] rr_next(input logic [2:0] a);
    return (a >= 3'd4) ? 3'd0 : a + 3'd1;
  endfunction

  // Inputs currently holding a wormhole lock on some output.
  always_comb begin
    owned = '0;
    for (int o = 0; o < 5; o++) begin
      if (state[o] == ST_LOCKED) owned[owner[o]] = 1'b1;
    end
  end

  // Head flits at free inputs asking for each output; out-of-range dests never match.
  always_comb begin
    cand = '0;
    for (int o = 0; o < 5; o++) begin
      for (int i = 0; i < 5; i++) begin
        cand[o][i] = in_req[i] & in_flit_id[3*i] &
                     (in_dest[3*i +: 3] == 3'(o)) & ~owned[i];
      end
    end
  end

  // Round-robin pick per output, scanning from rr[o] upward.
  always_comb begin
    win_found = '0;
    win_idx   = '0;
    for (int o = 0; o < 5; o++) begin
      logic [2:0] idx;
      idx = rr[o];
      for (int k = 0; k < 5; k++) begin
        if (!win_found[o] && cand[o][idx]) begin
          win_found[o] = 1'b1;
          win_idx[o]   = idx;
        end
        idx = rr_next(idx);
      end
    end
  end

  // Watchdog fire and flit transfer; a firing watchdog suppresses the grant that cycle.
  always_comb begin
    fire      = '0;
    xfer      = '0;
    tail_xfer = '0;
    for (int o = 0; o < 5; o++) begin
      fire[o] = !rst && (state[o] == ST_LOCKED) && (timeout_len != 12'd0) &&
                (stall[o] == timeout_len);
      xfer[o] = !rst && (state[o] == ST_LOCKED) && !fire[o] &&
                in_req[owner[o]] && (credit[o] != 4'd0);
      tail_xfer[o] = xfer[o] && in_flit_id[3*owner[o] + 2];
    end
  end

  // Crossbar selects, pops and status outputs derived from the lock state.
  always_comb begin
    in_grant    = '0;
    xbar_sel    = '0;
    out_valid   = xfer;
    timeout_err = fire;
    for (int o = 0; o < 5; o++) begin
      if (xfer[o]) in_grant[owner[o]] = 1'b1;
      if (state[o] == ST_LOCKED) xbar_sel[3*o +: 3] = owner[o];
    end
  end

  // Lock FSM, round-robin pointer, credit counter and stall counter per output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < 5; o++) begin
        state[o]  <= ST_IDLE;
        owner[o]  <= 3'd0;
        rr[o]     <= 3'd0;
        credit[o] <= CREDIT_MAX;
        stall[o]  <= 12'd0;
      end
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (xfer[o] && !credit_ret[o]) begin
          credit[o] <= credit[o] - 4'd1;
        end else if (!xfer[o] && credit_ret[o] && (credit[o] < CREDIT_MAX)) begin
          credit[o] <= credit[o] + 4'd1;
        end

        if (state[o] == ST_IDLE) begin
          stall[o] <= 12'd0;
          if (win_found[o]) begin
            state[o] <= ST_LOCKED;
            owner[o] <= win_idx[o];
          end
        end else if (fire[o] || tail_xfer[o]) begin
          state[o] <= ST_IDLE;
          rr[o]    <= rr_next(owner[o]);
          stall[o] <= 12'd0;
        end else if (xfer[o]) begin
          stall[o] <= 12'd0;
        end else if (stall[o] != 12'hfff) begin
          stall[o] <= stall[o] + 12'd1;
        end
      end
    end
  end

endmodule
